// File: rtl/stereo_echo_if.sv
// Audio-side signal bundle for the stereo echo core: frame clock, control
// settings, stereo samples in and out, and status flags.
interface stereo_echo_if #(
  parameter int BITSIZE = 16,
  parameter int ADDRLEN = 14
);
  logic                      lrclk;
  logic                      enable;
  logic                      pingpong;
  logic        [ADDRLEN-1:0] offset;
  logic        [BITSIZE-1:0] dry_gain;
  logic        [BITSIZE-1:0] wet_gain;
  logic        [BITSIZE-1:0] fb_gain;
  logic signed [BITSIZE-1:0] in_l;
  logic signed [BITSIZE-1:0] in_r;
  logic signed [BITSIZE-1:0] out_l;
  logic signed [BITSIZE-1:0] out_r;
  logic                      out_valid;
  logic                      ready;

  // Source side: the audio chain feeding samples and settings into the core
  modport master (
    output lrclk, enable, pingpong, offset, dry_gain, wet_gain, fb_gain, in_l, in_r,
    input  out_l, out_r, out_valid, ready
  );

  // Core side
  modport slave (
    input  lrclk, enable, pingpong, offset, dry_gain, wet_gain, fb_gain, in_l, in_r,
    output out_l, out_r, out_valid, ready
  );
endinterface

// File: rtl/stereo_echo.sv
// Stereo delay/echo with separate wet and feedback gains, optional ping-pong
// cross-feedback and saturating arithmetic. Both channels share one
// interleaved single-port sample RAM addressed as {frame_ptr, ch}.
// After reset the RAM is zeroed one word per cycle before ready is raised.
module stereo_echo #(
  parameter int BITSIZE = 16,
  parameter int ADDRLEN = 14
) (
  input logic          bclk,
  input logic          reset,
  stereo_echo_if.slave bus
);

  if (BITSIZE != 16 && BITSIZE != 24) begin : g_bad_bitsize
    $error("stereo_echo: BITSIZE must be 16 or 24");
  end

  localparam int DEPTH = 2 ** (ADDRLEN + 1);

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_L, S_RD_R, S_CAP_L, S_CAP_R, S_MUL, S_WR_L, S_WR_R, S_OUT
  } state_t;

  state_t                    state;
  logic                      lrclk_q;
  logic                      frame_start;
  logic        [ADDRLEN:0]   clr_cnt;
  logic        [ADDRLEN-1:0] wr_ptr;
  logic        [ADDRLEN-1:0] rd_ptr;

  // Sample RAM port (registered address/data, one-cycle read latency)
  logic signed [BITSIZE-1:0] mem [DEPTH];
  logic                      ram_we;
  logic        [ADDRLEN:0]   ram_addr;
  logic signed [BITSIZE-1:0] ram_wdata;
  logic signed [BITSIZE-1:0] ram_rdata;

  // p0: frame inputs and settings latched at frame start
  logic                      en_p0;
  logic signed [BITSIZE-1:0] in_l_p0;
  logic signed [BITSIZE-1:0] in_r_p0;
  logic        [BITSIZE-1:0] dry_p0;
  logic        [BITSIZE-1:0] wet_p0;
  logic        [BITSIZE-1:0] fb_p0;
  logic        [ADDRLEN-1:0] offset_p0;
  // p1: delay-line taps
  logic signed [BITSIZE-1:0] tap_l_p1;
  logic signed [BITSIZE-1:0] tap_r_p1;
  // p2: scaled products
  logic signed [BITSIZE-1:0] wet_l_p2;
  logic signed [BITSIZE-1:0] wet_r_p2;
  logic signed [BITSIZE-1:0] dry_l_p2;
  logic signed [BITSIZE-1:0] dry_r_p2;
  logic signed [BITSIZE-1:0] fb_l_p2;
  logic signed [BITSIZE-1:0] fb_r_p2;

  // Signed sample times unsigned Q0.BITSIZE gain, floored. The product is
  // formed at full width so the shifted result never overflows BITSIZE bits.
  function automatic logic signed [BITSIZE-1:0] gain_mul(
    input logic signed [BITSIZE-1:0] x,
    input logic        [BITSIZE-1:0] g
  );
    logic signed [2*BITSIZE:0] xe;
    logic signed [2*BITSIZE:0] ge;
    logic signed [2*BITSIZE:0] p;
    xe = {{(BITSIZE+1){x[BITSIZE-1]}}, x};
    ge = {{(BITSIZE+1){1'b0}}, g};
    p  = xe * ge;
    return p[2*BITSIZE-1:BITSIZE];
  endfunction

  // Two's-complement add clipped to the BITSIZE signed range.
  function automatic logic signed [BITSIZE-1:0] add_sat(
    input logic signed [BITSIZE-1:0] a,
    input logic signed [BITSIZE-1:0] b
  );
    logic signed [BITSIZE:0] s;
    s = $signed({a[BITSIZE-1], a}) + $signed({b[BITSIZE-1], b});
    if (s[BITSIZE] != s[BITSIZE-1])
      return s[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
    return s[BITSIZE-1:0];
  endfunction

  assign frame_start = bus.lrclk && !lrclk_q;
  assign rd_ptr      = wr_ptr - offset_p0;

  // Frame clock history for rising-edge detection
  always_ff @(posedge bclk) begin
    lrclk_q <= bus.lrclk;
  end

  // Control FSM: clear sequencing, frame sequencing, registered outputs
  always_ff @(posedge bclk) begin
    if (reset) begin
      state         <= S_CLEAR;
      clr_cnt       <= '0;
      wr_ptr        <= '0;
      ram_we        <= 1'b0;
      bus.ready     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_l     <= '0;
      bus.out_r     <= '0;
    end else begin
      ram_we        <= 1'b0;
      bus.out_valid <= 1'b0;
      case (state)
        S_CLEAR: begin
          ram_we  <= 1'b1;
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= S_IDLE;
        end
        S_IDLE: begin
          bus.ready <= 1'b1;
          if (frame_start) state <= S_RD_L;
        end
        S_RD_L:  state <= S_RD_R;
        S_RD_R:  state <= S_CAP_L;
        S_CAP_L: state <= S_CAP_R;
        S_CAP_R: state <= S_MUL;
        S_MUL:   state <= S_WR_L;
        S_WR_L: begin
          ram_we <= 1'b1;
          state  <= S_WR_R;
        end
        S_WR_R: begin
          ram_we <= 1'b1;
          state  <= S_OUT;
        end
        S_OUT: begin
          if (en_p0) begin
            bus.out_l <= add_sat(dry_l_p2, wet_l_p2);
            bus.out_r <= add_sat(dry_r_p2, wet_r_p2);
          end else begin
            bus.out_l <= in_l_p0;
            bus.out_r <= in_r_p0;
          end
          bus.out_valid <= 1'b1;
          wr_ptr        <= wr_ptr + 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Datapath: input latch, RAM address/data, taps and products
  always_ff @(posedge bclk) begin
    case (state)
      S_CLEAR: begin
        ram_addr  <= clr_cnt;
        ram_wdata <= '0;
      end
      // p0: latch samples and settings for the whole frame
      S_IDLE: begin
        if (frame_start) begin
          en_p0     <= bus.enable;
          in_l_p0   <= bus.in_l;
          in_r_p0   <= bus.in_r;
          dry_p0    <= bus.dry_gain;
          wet_p0    <= bus.wet_gain;
          fb_p0     <= bus.fb_gain;
          offset_p0 <= bus.offset;
        end
      end
      S_RD_L: ram_addr <= {rd_ptr, 1'b0};
      S_RD_R: ram_addr <= {rd_ptr, 1'b1};
      // p1: capture taps as they return from the RAM
      S_CAP_L: tap_l_p1 <= ram_rdata;
      S_CAP_R: tap_r_p1 <= ram_rdata;
      // p2: all gain products; ping-pong swaps the feedback source
      S_MUL: begin
        wet_l_p2 <= gain_mul(tap_l_p1, wet_p0);
        wet_r_p2 <= gain_mul(tap_r_p1, wet_p0);
        dry_l_p2 <= gain_mul(in_l_p0, dry_p0);
        dry_r_p2 <= gain_mul(in_r_p0, dry_p0);
        fb_l_p2  <= gain_mul(bus.pingpong ? tap_r_p1 : tap_l_p1, fb_p0);
        fb_r_p2  <= gain_mul(bus.pingpong ? tap_l_p1 : tap_r_p1, fb_p0);
      end
      S_WR_L: begin
        ram_addr  <= {wr_ptr, 1'b0};
        ram_wdata <= en_p0 ? add_sat(in_l_p0, fb_l_p2) : '0;
      end
      S_WR_R: begin
        ram_addr  <= {wr_ptr, 1'b1};
        ram_wdata <= en_p0 ? add_sat(in_r_p0, fb_r_p2) : '0;
      end
      default: ;
    endcase
  end

  // Single-port synchronous RAM
  always_ff @(posedge bclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

endmodule

// File: tb/tb_stereo_echo.sv
// Directed bench for stereo_echo at BITSIZE=16, ADDRLEN=4.
module tb_stereo_echo;
  localparam int BITSIZE = 16;
  localparam int ADDRLEN = 4;
  localparam int CLEAR_CYCLES = 2 ** (ADDRLEN + 1) + 1;

  logic bclk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   got_l;
  int   got_r;

  stereo_echo_if #(.BITSIZE(BITSIZE), .ADDRLEN(ADDRLEN)) bus ();

  stereo_echo #(.BITSIZE(BITSIZE), .ADDRLEN(ADDRLEN)) dut (
    .bclk  (bclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    int seen_v;
    int nz;
    @(negedge bclk);
    reset = 1'b1;
    bus.lrclk = 1'b0;
    repeat (2) @(negedge bclk);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_out_l", int'(bus.out_l), 0);
    chk("rst_out_r", int'(bus.out_r), 0);
    reset = 1'b0;
    n = 0;
    seen_v = 0;
    nz = 0;
    while (!bus.ready && n < 200) begin
      @(posedge bclk);
      #1;
      n++;
      if (bus.out_valid) seen_v = 1;
      if (bus.out_l != 0 || bus.out_r != 0) nz = 1;
    end
    chk("clear_cycles", n, CLEAR_CYCLES);
    chk("clear_valid", seen_v, 0);
    chk("clear_out", nz, 0);
  endtask

  task automatic run_frame(input int l, input int r);
    int vcount;
    int vcyc;
    @(negedge bclk);
    bus.in_l = BITSIZE'(l);
    bus.in_r = BITSIZE'(r);
    bus.lrclk = 1'b1;
    vcount = 0;
    vcyc = -1;
    got_l = -99999;
    got_r = -99999;
    for (int i = 0; i < 16; i++) begin
      @(negedge bclk);
      if (i == 6) bus.lrclk = 1'b0;
      if (bus.out_valid) begin
        vcount++;
        if (vcyc < 0) begin
          vcyc = i;
          got_l = int'(bus.out_l);
          got_r = int'(bus.out_r);
        end
      end
    end
    chk("valid_cnt", vcount, 1);
    chk("valid_lat", vcyc, 8);
  endtask

  task automatic frame_chk(input string tag, input int l, input int r, input int el, input int er);
    run_frame(l, r);
    chk({tag, "_l"}, got_l, el);
    chk({tag, "_r"}, got_r, er);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int el;
    int er;
    int nz;
    int sat_in_l [4] = '{32767, 0, 0, 32767};
    int sat_in_r [4] = '{-32768, 0, 0, -32768};
    int sat_ex_l [4] = '{32766, 0, 0, 32767};
    int sat_ex_r [4] = '{-32768, 0, 0, -32768};
    int byp_l [5] = '{100, 32767, -32768, 5, -1};
    int byp_r [5] = '{-200, -32768, 32767, 7, 1};

    bus.lrclk    = 1'b0;
    bus.enable   = 1'b1;
    bus.pingpong = 1'b0;
    bus.offset   = ADDRLEN'(3);
    bus.dry_gain = 16'h0000;
    bus.wet_gain = 16'hFFFF;
    bus.fb_gain  = 16'h0000;
    bus.in_l     = '0;
    bus.in_r     = '0;

    // Single echo, no feedback
    do_reset();
    for (int f = 0; f < 7; f++)
      frame_chk($sformatf("imp%0d", f), (f == 0) ? 16384 : 0, 0, (f == 3) ? 16383 : 0, 0);

    // Feedback halves the stored value each pass
    do_reset();
    bus.fb_gain = 16'h8000;
    for (int f = 0; f < 10; f++) begin
      el = (f == 3) ? 16383 : (f == 6) ? 8191 : (f == 9) ? 4095 : 0;
      frame_chk($sformatf("fb%0d", f), (f == 0) ? 16384 : 0, 0, el, 0);
    end

    // Ping-pong: echoes alternate L, R, L
    do_reset();
    bus.pingpong = 1'b1;
    for (int f = 0; f < 10; f++) begin
      el = (f == 3) ? 16383 : (f == 9) ? 4095 : 0;
      er = (f == 6) ? 8191 : 0;
      frame_chk($sformatf("pp%0d", f), (f == 0) ? 16384 : 0, 0, el, er);
    end

    // Saturation at both extremes
    do_reset();
    bus.pingpong = 1'b0;
    bus.fb_gain  = 16'h0000;
    bus.dry_gain = 16'hFFFF;
    for (int f = 0; f < 4; f++)
      frame_chk($sformatf("sat%0d", f), sat_in_l[f], sat_in_r[f], sat_ex_l[f], sat_ex_r[f]);

    // offset=0 is the full depth
    do_reset();
    bus.dry_gain = 16'h0000;
    bus.offset   = ADDRLEN'(0);
    for (int f = 0; f < 20; f++)
      frame_chk($sformatf("full%0d", f), (f == 0) ? 16384 : 0, 0, (f == 16) ? 16383 : 0, 0);

    // Tap read across the write-pointer wrap (write at 14, read back at 1)
    bus.offset = ADDRLEN'(3);
    for (int k = 0; k < 16; k++)
      frame_chk($sformatf("wrap%0d", k), 0, (k == 10) ? -1000 : 0, 0, (k == 13) ? -1000 : 0);

    // Bypass, then no echo of bypassed input after re-enable
    do_reset();
    bus.enable   = 1'b0;
    bus.dry_gain = 16'h1234;
    bus.fb_gain  = 16'h8000;
    bus.offset   = ADDRLEN'(1);
    for (int f = 0; f < 5; f++)
      frame_chk($sformatf("byp%0d", f), byp_l[f], byp_r[f], byp_l[f], byp_r[f]);
    bus.enable = 1'b1;
    for (int f = 0; f < 3; f++)
      frame_chk($sformatf("reen%0d", f), 0, 0, 0, 0);

    // Reset asserted while the FSM sits in MUL
    do_reset();
    bus.dry_gain = 16'h0000;
    bus.fb_gain  = 16'h0000;
    frame_chk("pre0", 1000, 2000, 0, 0);
    frame_chk("pre1", 0, 0, 999, 1999);
    @(negedge bclk);
    bus.in_l = 16'sd3000;
    bus.in_r = 16'sd4000;
    bus.lrclk = 1'b1;
    repeat (5) @(negedge bclk);
    reset = 1'b1;
    bus.lrclk = 1'b0;
    @(negedge bclk);
    chk("mul_rst_mem_l", int'(dut.mem[4]), 0);
    chk("mul_rst_mem_r", int'(dut.mem[5]), 0);
    chk("mul_rst_keep", int'(dut.mem[0]), 1000);
    chk("mul_rst_out_l", int'(bus.out_l), 0);
    chk("mul_rst_out_r", int'(bus.out_r), 0);
    chk("mul_rst_ready", int'(bus.ready), 0);
    do_reset();
    nz = 0;
    for (int i = 0; i < 2 ** (ADDRLEN + 1); i++)
      if (dut.mem[i] != 0) nz++;
    chk("mem_cleared", nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
